// File: rtl/rr_arb4_decode.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4_decode
// Description : Round-robin arbiter that shares one resource between four
//               clients. It registers the winner as a 2-bit index and decodes
//               that index into a one-hot grant. Each grant runs through
//               acquire, hold and release. Every release is followed by one
//               mandatory IDLE cycle.
//
//               Optional feature macro: HOLD_TIMEOUT_EN
//                 defined   - a grant is forcibly released after HOLD_MAX
//                             consecutive GRANT cycles, and 'timeout'
//                             pulses for one cycle.
//                 undefined - the grant is held until done or until the
//                             owner withdraws its request. The timeout
//                             port and the hold counter are not built.
//
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset
//               req[3:0] - per-client request, held high until served
//               done     - owner releases the resource (GRANT only)
//               gnt[3:0] - one-hot grant, 0000 when not in GRANT
//               gnt_idx  - encoded owner index, valid while busy=1
//               busy     - high while in GRANT
//               timeout  - one-cycle forced-release pulse (macro only)
//
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb4_decode #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy
`ifdef HOLD_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    // Reject configurations where the counter cannot reach HOLD_MAX.
    generate
        if ((HOLD_MAX < 1) || (HOLD_MAX > 255) || ((2 ** CNT_W) <= HOLD_MAX)) begin : g_cfg_err
            $error("rr_arb4_decode: illegal HOLD_MAX / CNT_W combination");
        end
    endgenerate

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] r_idx;
    logic [1:0] w_win;
    logic       w_any;
    logic       w_withdraw;
    logic       w_release;

`ifdef HOLD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] c_HOLD_SAT  = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] r_cnt;
    logic             w_force;
    logic             r_timeout;
`endif

    // ------------------------------------------------------------------------
    // Round-robin pick. The scan runs from the farthest offset down to the
    // nearest, so the closest asserted request at or after r_ptr is written
    // last and wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_any = |req;
        w_win = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[r_ptr + 2'(i)]) begin
                w_win = r_ptr + 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Release conditions. done and withdrawal in the same cycle merge into a
    // single release. A forced release is flagged only when nothing else
    // would have released the grant on this edge.
    // ------------------------------------------------------------------------
    assign w_withdraw = ~req[r_idx];

`ifdef HOLD_TIMEOUT_EN
    // r_cnt holds the number of GRANT cycles already completed. When it
    // equals HOLD_MAX-1, the current cycle is the HOLD_MAX-th cycle.
    assign w_force   = (r_cnt == c_HOLD_LAST) && ~done && ~w_withdraw;
    assign w_release = done | w_withdraw | w_force;
`else
    assign w_release = done | w_withdraw;
`endif

    // ------------------------------------------------------------------------
    // State register, including pointer and owner index.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= 2'b00;
            r_idx   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_IDLE) && w_any) begin
                r_idx <= w_win;
            end
            // The releasing owner moves to the lowest priority.
            if ((r_state == c_GRANT) && w_release) begin
                r_ptr <= r_idx + 2'b01;
            end
        end
    end

`ifdef HOLD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == c_GRANT) && w_force;
            if (r_state == c_IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt != c_HOLD_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_any)     w_state_nxt = c_GRANT;
            c_GRANT: if (w_release) w_state_nxt = c_IDLE;
            default:                w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded only from registered state.
    // ------------------------------------------------------------------------
    always_comb begin
        busy = (r_state == c_GRANT);
        gnt  = 4'b0000;
        if (r_state == c_GRANT) begin
            gnt[r_idx] = 1'b1;
        end
    end

    assign gnt_idx = r_idx;

`ifdef HOLD_TIMEOUT_EN
    assign timeout = r_timeout;
`endif

endmodule
`default_nettype wire

// File: doc/rr_arb4_decode.md
Name: rr_arb4_decode

Overview:
- 4-requester round-robin arbiter that shares one resource between four clients.
- Winner index is registered as a 2-bit code, then driven through 2-to-4 decode logic to form a one-hot grant vector.
- Sits between four client request lines and the shared resource's select/enable inputs, and sequences acquire → hold → release for each client.

Parameters:
- HOLD_MAX, 8, maximum consecutive GRANT cycles per grant (range 1–255). Used only when HOLD_TIMEOUT_EN is defined.
- CNT_W, 8, width of the hold counter. Must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  4  request per client; held high until served
- done  input  1  current owner releases the resource; sampled only in GRANT
- gnt  output  4  one-hot grant = decode(gnt_idx) while in GRANT, else 4'b0000
- gnt_idx  output  2  encoded owner index; valid only while busy=1
- busy  output  1  high in GRANT state
- timeout  output  1  one-cycle pulse on forced release (exists only with HOLD_TIMEOUT_EN)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - state=IDLE, gnt=0000, gnt_idx=00, busy=0, timeout=0.
  - Priority pointer ptr=00; hold counter=0.
  - rst overrides all other inputs in the same cycle, including mid-grant: gnt drops to 0000 on the next edge and no release is recorded.
- Registers: state (IDLE/GRANT), ptr[1:0], gnt_idx[1:0], hold counter. All outputs are registered or decoded from registered state only; no combinational path from req/done to gnt.
- IDLE:
  - If req != 0000: pick the first asserted bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On that edge: load gnt_idx, go to GRANT, clear counter.
  - Latency: req high at edge k → gnt valid after edge k (1 cycle).
  - If req == 0000: stay in IDLE; outputs unchanged at 0.
- GRANT:
  - gnt = one-hot of gnt_idx (00→0001, 01→0010, 10→0100, 11→1000); busy=1.
  - Counter increments each GRANT cycle, saturating at HOLD_MAX.
  - Release when any of:
    - done=1;
    - req[gnt_idx]=0 (requester withdrew);
    - timeout condition (feature only).
  - On release: next state IDLE, ptr=gnt_idx+1 (11 wraps to 00), gnt=0000 on the next edge.
  - done while not in GRANT is ignored.
- Re-arbitration:
  - One mandatory IDLE cycle after every release, so gnt is never back-to-back and resource turnover is guaranteed.
  - A releasing client that still holds req has lowest priority in the next arbitration.
- Simultaneous events:
  - done and req withdrawal in the same cycle count as a single release.
  - New req bits arriving during GRANT are not seen until the next IDLE cycle.
  - Only one gnt bit may ever be high.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,…; each client waits at most 3 grants.

Optional Feature:
- Macro: HOLD_TIMEOUT_EN.
- Defined:
  - When the counter reaches HOLD_MAX with no done, force release on that edge.
  - Assert timeout for exactly one cycle, coincident with the first IDLE cycle.
  - ptr advances as for a normal release.
- Undefined:
  - No timeout port, no counter logic.
  - Hold is unbounded; release only via done or req withdrawal.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0000 → gnt=0000, busy=0, gnt_idx=00 for 10 cycles.
- Single request: req=0100 → gnt=0100, gnt_idx=10, busy=1 one edge later; done pulse → gnt=0000 next edge; next grant is searched from ptr=11.
- Rotation: req=1111 held, done pulsed each grant → gnt sequence 0001,0010,0100,1000,0001, with one 0000 cycle between each.
- Withdrawal/simultaneous: owner 01 drops req[1] while done=1 in the same cycle → one release only, ptr=10; a req[3] raised mid-grant is served next.
- Timeout (HOLD_TIMEOUT_EN, HOLD_MAX=8): req=0001, never done → gnt=0001 for exactly 8 cycles, then gnt=0000 with timeout=1 for 1 cycle, then regrant 0001.
- Reset mid-grant: gnt=1000 active, assert rst 1 cycle → gnt=0000, ptr=00 next edge; with req=1001, first post-reset grant is 0001.
